// File: rtl/mips_mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: global width defines,
// FSM state encodings and a small address helper.
// Optional feature macro: MIPS_MEM_ALIGN_CHK_EN (word-alignment check).

`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif
`ifndef MIPS_ADDR_WIDTH
`define MIPS_ADDR_WIDTH 32
`endif
`ifndef MIPS_RFIDX_WIDTH
`define MIPS_RFIDX_WIDTH 5
`endif

package mips_mem_lsu_pkg;

    localparam int MIPS_LSU_ST_WIDTH = 2;

    typedef enum logic [MIPS_LSU_ST_WIDTH-1:0] {
        MIPS_LSU_ST_IDLE = 2'd0,
        MIPS_LSU_ST_REQ  = 2'd1,
        MIPS_LSU_ST_WAIT = 2'd2
    } lsu_state_e;

    // A word access is misaligned when either of the two byte-offset bits is set.
    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs != 2'b00);
    endfunction

endpackage

// File: rtl/mips_mem_lsu_if.sv
// Data-memory request/response channel between the LSU (master) and the
// data memory (slave). One response is returned per accepted request.

interface mips_mem_lsu_if;

    logic                         dmem_req_valid;
    logic                         dmem_req_ready;
    logic                         dmem_req_write;
    logic [`MIPS_ADDR_WIDTH-1:0]  dmem_req_addr;
    logic [`MIPS_DATA_WIDTH-1:0]  dmem_req_wdat;
    logic                         dmem_rsp_valid;
    logic [`MIPS_DATA_WIDTH-1:0]  dmem_rsp_rdat;

    modport master (
        output dmem_req_valid, dmem_req_write, dmem_req_addr, dmem_req_wdat,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdat
    );

    modport slave (
        input  dmem_req_valid, dmem_req_write, dmem_req_addr, dmem_req_wdat,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdat
    );

endinterface

// File: rtl/mips_mem_wb_reg.sv
// MEM-to-WB pipeline register. valid and misalign are single-cycle pulses
// that follow the load enable; the destination fields hold between loads.

module mips_mem_wb_reg (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_load,
    input  logic [`MIPS_RFIDX_WIDTH-1:0]  i_rd_idx,
    input  logic [`MIPS_DATA_WIDTH-1:0]   i_rd_wdat,
    input  logic                          i_rd_wen,
    input  logic                          i_misalign,
    output logic                          o_valid,
    output logic [`MIPS_RFIDX_WIDTH-1:0]  o_rd_idx,
    output logic [`MIPS_DATA_WIDTH-1:0]   o_rd_wdat,
    output logic                          o_rd_wen,
    output logic                          o_misalign
);

    logic                          r_valid;
    logic [`MIPS_RFIDX_WIDTH-1:0]  r_rd_idx;
    logic [`MIPS_DATA_WIDTH-1:0]   r_rd_wdat;
    logic                          r_rd_wen;
    logic                          r_misalign;

    // Capture write-back fields on load; valid/misalign drop when nothing is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_rd_idx   <= '0;
            r_rd_wdat  <= '0;
            r_rd_wen   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_valid    <= i_load;
            r_misalign <= i_load & i_misalign;
            if (i_load) begin
                r_rd_idx  <= i_rd_idx;
                r_rd_wdat <= i_rd_wdat;
                r_rd_wen  <= i_rd_wen;
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_rd_idx   = r_rd_idx;
    assign o_rd_wdat  = r_rd_wdat;
    assign o_rd_wen   = r_rd_wen;
    assign o_misalign = r_misalign;

endmodule

// File: rtl/mips_mem_lsu.sv
// MEM-stage load/store unit: one outstanding data-memory transaction,
// upstream stall while busy, registered MEM-to-WB outputs.
// Optional feature macro: MIPS_MEM_ALIGN_CHK_EN - misaligned loads/stores are
// not issued and are reported through mem2wb_misalign instead.

module mips_mem_lsu
    import mips_mem_lsu_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ex2mem_valid,
    input  logic                          ex2mem_mem_read,
    input  logic                          ex2mem_mem_write,
    input  logic [`MIPS_ADDR_WIDTH-1:0]   ex2mem_mem_addr,
    input  logic [`MIPS_DATA_WIDTH-1:0]   ex2mem_mem_wdat,
    input  logic [`MIPS_RFIDX_WIDTH-1:0]  ex2mem_rd_idx,
    input  logic [`MIPS_DATA_WIDTH-1:0]   ex2mem_rd_wdat,
    input  logic                          ex2mem_rd_wen,
    output logic                          mem_stall,
    mips_mem_lsu_if.master                dmem,
    output logic                          mem2wb_valid,
    output logic [`MIPS_RFIDX_WIDTH-1:0]  mem2wb_rd_idx,
    output logic [`MIPS_DATA_WIDTH-1:0]   mem2wb_rd_wdat,
    output logic                          mem2wb_rd_wen,
    output logic                          mem2wb_misalign
);

    lsu_state_e                    r_state;
    lsu_state_e                    w_state_nxt;

    logic [`MIPS_ADDR_WIDTH-1:0]   r_addr;
    logic [`MIPS_DATA_WIDTH-1:0]   r_wdat;
    logic                          r_write;
    logic [`MIPS_RFIDX_WIDTH-1:0]  r_rd_idx;
    logic                          r_rd_wen;

    logic                          w_misalign;
    logic                          w_is_store;
    logic                          w_hold_load;
    logic                          w_wb_load;
    logic [`MIPS_RFIDX_WIDTH-1:0]  w_wb_rd_idx;
    logic [`MIPS_DATA_WIDTH-1:0]   w_wb_rd_wdat;
    logic                          w_wb_rd_wen;
    logic                          w_wb_misalign;

`ifdef MIPS_MEM_ALIGN_CHK_EN
    assign w_misalign = is_misaligned(ex2mem_mem_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // Read wins when both read and write are requested.
    assign w_is_store = ex2mem_mem_write & ~ex2mem_mem_read;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MIPS_LSU_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic plus the write-back and holding-register load controls.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_load   = 1'b0;
        w_wb_load     = 1'b0;
        w_wb_rd_idx   = r_rd_idx;
        w_wb_rd_wdat  = {`MIPS_DATA_WIDTH{1'b0}};
        w_wb_rd_wen   = 1'b0;
        w_wb_misalign = 1'b0;
        case (r_state)
            MIPS_LSU_ST_IDLE: begin
                if (ex2mem_valid) begin
                    if (ex2mem_mem_read | ex2mem_mem_write) begin
                        if (w_misalign) begin
                            w_wb_load     = 1'b1;
                            w_wb_rd_idx   = ex2mem_rd_idx;
                            w_wb_misalign = 1'b1;
                        end else begin
                            w_hold_load = 1'b1;
                            w_state_nxt = MIPS_LSU_ST_REQ;
                        end
                    end else begin
                        w_wb_load    = 1'b1;
                        w_wb_rd_idx  = ex2mem_rd_idx;
                        w_wb_rd_wdat = ex2mem_rd_wdat;
                        w_wb_rd_wen  = ex2mem_rd_wen;
                    end
                end else begin
                    w_state_nxt = MIPS_LSU_ST_IDLE;
                end
            end
            MIPS_LSU_ST_REQ: begin
                if (dmem.dmem_req_ready) begin
                    w_state_nxt = MIPS_LSU_ST_WAIT;
                end else begin
                    w_state_nxt = MIPS_LSU_ST_REQ;
                end
            end
            MIPS_LSU_ST_WAIT: begin
                if (dmem.dmem_rsp_valid) begin
                    w_wb_load    = 1'b1;
                    w_wb_rd_idx  = r_rd_idx;
                    w_wb_rd_wdat = r_write ? {`MIPS_DATA_WIDTH{1'b0}} : dmem.dmem_rsp_rdat;
                    w_wb_rd_wen  = r_write ? 1'b0 : r_rd_wen;
                    w_state_nxt  = MIPS_LSU_ST_IDLE;
                end else begin
                    w_state_nxt = MIPS_LSU_ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = MIPS_LSU_ST_IDLE;
            end
        endcase
    end

    // Holding registers: the request payload and destination of the memory op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_wdat   <= '0;
            r_write  <= 1'b0;
            r_rd_idx <= '0;
            r_rd_wen <= 1'b0;
        end else if (w_hold_load) begin
            r_addr   <= ex2mem_mem_addr;
            r_wdat   <= ex2mem_mem_wdat;
            r_write  <= w_is_store;
            r_rd_idx <= ex2mem_rd_idx;
            r_rd_wen <= ex2mem_rd_wen;
        end
    end

    assign mem_stall           = (r_state != MIPS_LSU_ST_IDLE);
    assign dmem.dmem_req_valid = (r_state == MIPS_LSU_ST_REQ);
    assign dmem.dmem_req_write = r_write;
    assign dmem.dmem_req_addr  = r_addr;
    assign dmem.dmem_req_wdat  = r_wdat;

    mips_mem_wb_reg u_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_wb_load),
        .i_rd_idx   (w_wb_rd_idx),
        .i_rd_wdat  (w_wb_rd_wdat),
        .i_rd_wen   (w_wb_rd_wen),
        .i_misalign (w_wb_misalign),
        .o_valid    (mem2wb_valid),
        .o_rd_idx   (mem2wb_rd_idx),
        .o_rd_wdat  (mem2wb_rd_wdat),
        .o_rd_wen   (mem2wb_rd_wen),
        .o_misalign (mem2wb_misalign)
    );

endmodule

// File: tb/tb_mips_mem_lsu.sv
// Scoreboard bench for mips_mem_lsu: an upstream driver, a data-memory
// responder and an output monitor run as separate processes.

module tb_mips_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex2mem_valid, ex2mem_mem_read, ex2mem_mem_write, ex2mem_rd_wen;
    logic [31:0] ex2mem_mem_addr, ex2mem_mem_wdat, ex2mem_rd_wdat;
    logic [4:0]  ex2mem_rd_idx;
    logic        mem_stall, mem2wb_valid, mem2wb_rd_wen, mem2wb_misalign;
    logic [4:0]  mem2wb_rd_idx;
    logic [31:0] mem2wb_rd_wdat;

    mips_mem_lsu_if dmem_if ();

    mips_mem_lsu dut (
        .clk              (clk),
        .rst              (rst),
        .ex2mem_valid     (ex2mem_valid),
        .ex2mem_mem_read  (ex2mem_mem_read),
        .ex2mem_mem_write (ex2mem_mem_write),
        .ex2mem_mem_addr  (ex2mem_mem_addr),
        .ex2mem_mem_wdat  (ex2mem_mem_wdat),
        .ex2mem_rd_idx    (ex2mem_rd_idx),
        .ex2mem_rd_wdat   (ex2mem_rd_wdat),
        .ex2mem_rd_wen    (ex2mem_rd_wen),
        .mem_stall        (mem_stall),
        .dmem             (dmem_if.master),
        .mem2wb_valid     (mem2wb_valid),
        .mem2wb_rd_idx    (mem2wb_rd_idx),
        .mem2wb_rd_wdat   (mem2wb_rd_wdat),
        .mem2wb_rd_wen    (mem2wb_rd_wen),
        .mem2wb_misalign  (mem2wb_misalign)
    );

    always #5 clk = ~clk;

`ifdef MIPS_MEM_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    // kind: 0 = non-memory op, 1 = memory op, 2 = misaligned (rejected) op
    typedef struct {
        int          kind;
        logic [4:0]  idx;
        logic [31:0] wdat;
        logic        wen;
        int          due;
    } wb_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdat;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];
    int   rsp_cyc_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   busy = 1'b0;

    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] dmem_arr [logic [31:0]];

    int  fixed_ready = -1;
    int  fixed_rsp   = -1;
    bit  spurious_en = 1'b0;
    bit  hold_rsp    = 1'b0;
    bit  inject_late = 1'b0;
    bit  rsp_pend    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    task automatic idle();
        ex2mem_valid     = 1'b0;
        ex2mem_mem_read  = 1'($urandom_range(0, 1));
        ex2mem_mem_write = 1'($urandom_range(0, 1));
        ex2mem_mem_addr  = $urandom;
        ex2mem_rd_wdat   = $urandom;
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdat, input logic [4:0] idx,
                         input logic [31:0] rwd, input logic wen);
        int   guard = 0;
        bit   acc = 1'b0;
        bit   memop, mis;
        wb_t  e;
        req_t r;
        ex2mem_valid     = 1'b1;
        ex2mem_mem_read  = rd;
        ex2mem_mem_write = wr;
        ex2mem_mem_addr  = addr;
        ex2mem_mem_wdat  = wdat;
        ex2mem_rd_idx    = idx;
        ex2mem_rd_wdat   = rwd;
        ex2mem_rd_wen    = wen;
        memop = rd | wr;
        mis   = ALIGN && (addr[1:0] != 2'b00);
        while (!acc && guard < 100) begin
            @(negedge clk);
            guard++;
            acc = !mem_stall;
            if (acc) begin
                if (!memop) begin
                    e = '{0, idx, rwd, wen, cyc + 1};
                end else if (mis) begin
                    e = '{2, idx, 32'h0, 1'b0, cyc + 1};
                end else begin
                    r = '{wr & ~rd, addr, wdat};
                    req_q.push_back(r);
                    if (wr && !rd) begin
                        ref_mem[addr] = wdat;
                        e = '{1, idx, 32'h0, 1'b0, 0};
                    end else begin
                        e = '{1, idx, ref_read(addr), wen, 0};
                    end
                end
                wb_q.push_back(e);
            end
            @(posedge clk); #1;
            if (acc && memop && !mis) busy = 1'b1;
        end
        if (!acc) chk("issue_timeout", 32'd1, 32'd0);
    endtask

    // ---------------- data-memory responder ----------------
    initial begin : responder
        bit          acc_last  = 1'b0;
        bit          sent_last = 1'b0;
        int          wcnt = 0;
        int          rdy_wait = -1;
        logic [31:0] rdat = 32'h0;
        dmem_if.dmem_req_ready = 1'b0;
        dmem_if.dmem_rsp_valid = 1'b0;
        dmem_if.dmem_rsp_rdat  = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (sent_last) begin
                busy = 1'b0;
                sent_last = 1'b0;
            end
            if (acc_last) begin
                rsp_pend = 1'b1;
                wcnt = (fixed_rsp >= 0) ? fixed_rsp : int'($urandom_range(0, 2));
                acc_last = 1'b0;
            end
            dmem_if.dmem_req_ready = 1'b0;
            dmem_if.dmem_rsp_valid = 1'b0;
            dmem_if.dmem_rsp_rdat  = $urandom;
            if (rsp_pend && !hold_rsp) begin
                if (wcnt == 0) begin
                    dmem_if.dmem_rsp_valid = 1'b1;
                    dmem_if.dmem_rsp_rdat  = rdat;
                    rsp_pend  = 1'b0;
                    sent_last = 1'b1;
                    rsp_cyc_q.push_back(cyc);
                end else begin
                    wcnt--;
                end
            end else if (rsp_pend && hold_rsp && inject_late) begin
                dmem_if.dmem_rsp_valid = 1'b1;
                rsp_pend    = 1'b0;
                inject_late = 1'b0;
            end else if (!rsp_pend && dmem_if.dmem_req_valid) begin
                if (rdy_wait < 0)
                    rdy_wait = (fixed_ready >= 0) ? fixed_ready : int'($urandom_range(0, 3));
                if (rdy_wait == 0) begin
                    dmem_if.dmem_req_ready = 1'b1;
                    acc_last = 1'b1;
                    rdy_wait = -1;
                    if (dmem_if.dmem_req_write)
                        dmem_arr[dmem_if.dmem_req_addr] = dmem_if.dmem_req_wdat;
                    else
                        rdat = dmem_arr.exists(dmem_if.dmem_req_addr) ?
                               dmem_arr[dmem_if.dmem_req_addr] : init_word(dmem_if.dmem_req_addr);
                end else begin
                    rdy_wait--;
                end
                if (spurious_en && $urandom_range(0, 3) == 0) dmem_if.dmem_rsp_valid = 1'b1;
            end else if (!rsp_pend && spurious_en && $urandom_range(0, 3) == 0) begin
                dmem_if.dmem_rsp_valid = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        wb_t  e;
        req_t r;
        int   rc;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            chk("mem_stall", {31'h0, mem_stall}, {31'h0, busy});
            if (dmem_if.dmem_req_valid) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", 32'd1, 32'd0);
                end else begin
                    r = req_q[0];
                    chk("req_addr", dmem_if.dmem_req_addr, r.addr);
                    chk("req_write", {31'h0, dmem_if.dmem_req_write}, {31'h0, r.wr});
                    chk("req_wdat", dmem_if.dmem_req_wdat, r.wdat);
                    if (dmem_if.dmem_req_ready) void'(req_q.pop_front());
                end
            end
            if (mem2wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_wen", {31'h0, mem2wb_rd_wen}, {31'h0, e.wen});
                    chk("wb_misalign", {31'h0, mem2wb_misalign}, {31'h0, (e.kind == 2)});
                    if (e.kind != 2) begin
                        chk("wb_idx", {27'h0, mem2wb_rd_idx}, {27'h0, e.idx});
                        chk("wb_wdat", mem2wb_rd_wdat, e.wdat);
                    end
                    if (e.kind == 1) begin
                        if (rsp_cyc_q.size() == 0) begin
                            chk("wb_no_response", 32'd1, 32'd0);
                        end else begin
                            rc = rsp_cyc_q.pop_front();
                            chk("wb_mem_latency", cyc, rc + 1);
                        end
                    end else begin
                        chk("wb_latency", cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'h0, mem_stall}, 32'h0);
        chk({tag, "_req_valid"}, {31'h0, dmem_if.dmem_req_valid}, 32'h0);
        chk({tag, "_req_write"}, {31'h0, dmem_if.dmem_req_write}, 32'h0);
        chk({tag, "_req_addr"}, dmem_if.dmem_req_addr, 32'h0);
        chk({tag, "_req_wdat"}, dmem_if.dmem_req_wdat, 32'h0);
        chk({tag, "_wb_valid"}, {31'h0, mem2wb_valid}, 32'h0);
        chk({tag, "_wb_idx"}, {27'h0, mem2wb_rd_idx}, 32'h0);
        chk({tag, "_wb_wdat"}, mem2wb_rd_wdat, 32'h0);
        chk({tag, "_wb_wen"}, {31'h0, mem2wb_rd_wen}, 32'h0);
        chk({tag, "_wb_misalign"}, {31'h0, mem2wb_misalign}, 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic        rd, wr;
        logic [31:0] addr;
        int          guard;
        rst = 1'b1;
        ex2mem_valid = 1'b0; ex2mem_mem_read = 1'b0; ex2mem_mem_write = 1'b0;
        ex2mem_mem_addr = 32'h0; ex2mem_mem_wdat = 32'h0;
        ex2mem_rd_idx = 5'h0; ex2mem_rd_wdat = 32'h0; ex2mem_rd_wen = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Non-memory op.
        issue(1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 32'h0000_1234, 1'b1);
        idle();

        // Load, ready immediately, response one cycle later.
        fixed_ready = 0; fixed_rsp = 0;
        issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 32'h0, 1'b1);
        idle(); repeat (4) idle();

        // Store with ready held low for three cycles.
        fixed_ready = 3;
        issue(1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 5'd9, 32'h0, 1'b1);
        idle(); repeat (7) idle();

        // Load immediately followed by an ALU op held by the stall; then read back the store.
        fixed_ready = 0;
        issue(1'b1, 1'b0, 32'h0000_0200, 32'h0, 5'd3, 32'h0, 1'b1);
        issue(1'b0, 1'b0, 32'h0, 32'h0, 5'd4, 32'h0000_0044, 1'b1);
        // Read and write both set behaves as a load.
        issue(1'b1, 1'b1, 32'h0000_0100, 32'h1111_2222, 5'd6, 32'h0, 1'b0);
        // Misaligned load.
        issue(1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd8, 32'h0, 1'b1);
        idle(); repeat (5) idle();

        // Randomized traffic.
        fixed_ready = -1; fixed_rsp = -1; spurious_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) idle();
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin rd = 1'b0; wr = 1'b0; end
                4, 5, 6:    begin rd = 1'b1; wr = 1'b0; end
                7, 8:       begin rd = 1'b0; wr = 1'b1; end
                default:    begin rd = 1'b1; wr = 1'b1; end
            endcase
            addr = 32'h0000_1000 + {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 9) == 0) addr = addr + 32'($urandom_range(1, 3));
            issue(rd, wr, addr, $urandom, 5'($urandom), $urandom, 1'($urandom_range(0, 1)));
        end
        idle();
        spurious_en = 1'b0;
        guard = 0;
        while ((busy || wb_q.size() != 0) && guard < 200) begin idle(); guard++; end
        chk("drain_random", wb_q.size(), 32'd0);

        // Reset while waiting for a response, followed by a late response.
        hold_rsp = 1'b1; fixed_ready = 0;
        issue(1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd10, 32'h0, 1'b1);
        ex2mem_valid = 1'b0;
        guard = 0;
        while (!rsp_pend && guard < 20) begin @(negedge clk); guard++; end
        chk("reach_wait", {31'h0, rsp_pend}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        busy = 1'b0;
        wb_q.delete();
        req_q.delete();
        inject_late = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        repeat (4) idle();
        chk_all_zero("late_rsp");
        hold_rsp = 1'b0;

        // Normal operation resumes after the abort.
        fixed_rsp = 1;
        issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd11, 32'h0, 1'b1);
        idle();
        guard = 0;
        while ((busy || wb_q.size() != 0) && guard < 50) begin idle(); guard++; end
        chk("drain_final", wb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
